mem_bank_arbiter: RTL and testbench
===================================

// Module: mem_bank_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and access sequencer for one byte-wide data memory
//  bank: synchronous write, combinational read, 8-bit address, MemRead/MemWrite strobes.
//  Lets two datapath units share one bank. Each access is a 3-cycle transaction with
//  a per-requester Ack and registered read data.
// PARAMETERS
//  AW  8  address width (bank depth 2**AW)
//  DW  8  data width
// PORTS
//  Clk       in   1   clock, rising edge
//  Rst       in   1   synchronous, active-high reset
//  Req0      in   1   requester 0 access request (level)
//  We0       in   1   requester 0: 1 = write, 0 = read
//  Addr0     in   AW  requester 0 address
//  WData0    in   DW  requester 0 write data
//  Ack0      out  1   1-cycle pulse: requester 0 transaction complete
//  Req1/We1/Addr1/WData1/Ack1  same as above, for requester 1
//  RData     out  DW  read data; valid while Ack0 or Ack1 is high for a read
//  Busy      out  1   high in ACCESS and DONE
//  MemAddr   out  AW  to bank Address
//  MemWData  out  DW  to bank WriteData
//  MemWrite  out  1   to bank MemWrite
//  MemRead   out  1   to bank MemRead
//  MemRData  in   DW  from bank ReadData (combinational, 0 when MemRead=0)
// BEHAVIOUR
//  Reset: state=IDLE; Ack0=Ack1=0; RData=0; Busy=0; MemWrite=MemRead=0;
//   MemAddr=MemWData=0; last-grant pointer=1, so requester 0 wins first.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. No other states. Unused encodings go to IDLE.
//  IDLE: at a clock edge where at least one Req is high, choose the winner.
//   - Only one Req high: that requester wins.
//   - Both high: the requester that is not the last-grant pointer wins.
//   - Latch the winner id and its We/Addr/WData into internal regs. Go to ACCESS.
//   - No Req high: stay in IDLE.
//  ACCESS: drive MemAddr and MemWData from the latched regs.
//   - MemWrite = latched We & ~Rst; MemRead = ~latched We & ~Rst.
//   - A write commits in the bank on the edge that ends ACCESS.
//   - For a read, RData <= MemRData on that edge. For a write, RData keeps its value.
//   - Go to DONE.
//  DONE: Ack of the winner = 1, other Ack = 0. MemWrite = MemRead = 0.
//   - Last-grant pointer <= winner. Go to IDLE.
//  Outside ACCESS, MemAddr/MemWData hold the last latched value (no glitching to 0).
//  Latency: Req sampled at edge N -> mem access during cycle N+1 -> Ack high in cycle N+2.
//   - Peak throughput: 1 transaction per 3 cycles.
//  Handshake: a requester holds Req/We/Addr/WData stable until it sees Ack.
//   - It may drop Req on the edge where Ack is sampled high.
//   - If Req is still high in the IDLE cycle after Ack, that is a new request.
//   - Req dropped mid-transaction: ignored. The transaction completes and Ack still pulses.
//  Fairness: with both Req held high continuously, grants alternate 0,1,0,1...
//   - Neither requester waits more than one transaction.
//  Ack0 and Ack1 are never high in the same cycle.
//  Address wrap: none. Every AW-bit address is valid, including 0 and 2**AW-1.
//  Reset mid-operation: Rst has priority in every state.
//   - A write in ACCESS while Rst=1 does not commit, because MemWrite is gated by Rst.
//   - No Ack is issued for the aborted transaction. The latched request is discarded.
// TESTING
//  1 Req0 write Addr0=8'h10, WData0=8'hA5, then Req0 read 8'h10 -> Ack0 2 cycles
//    after Req sampled each time; RData=8'hA5 with Ack0; Ack1 stays 0.
//  2 Req0 and Req1 rise together after reset, both reads -> Ack0 first, Ack1 3 cycles
//    later; both held high -> grant order 0,1,0,1.
//  3 Req1 alone write 8'hFF->Addr 8'hFF, Req0 read 8'hFF -> RData=8'hFF, no
//    address wrap; write to 8'h00 leaves 8'hFF unchanged.
//  4 Req1 write 8'h3C->8'h20, Rst=1 during ACCESS -> MemWrite=0 that cycle, no Ack;
//    after reset, Req0 read 8'h20 returns the old value, not 8'h3C.
//  5 Req0 read issued, Req0 dropped during ACCESS -> Ack0 still pulses once with
//    valid RData; FSM returns to IDLE; Busy=0.
//  6 Idle bench with Req0=Req1=0 for 20 cycles -> MemWrite=MemRead=0,
//    Ack0=Ack1=0, Busy=0 throughout.

Source files
------------

// File: rtl/mem_bank_arbiter_if.sv
// Requester-side bus for mem_bank_arbiter: one instance per requester.
//   req   level request, held until ack
//   we    1 = write, 0 = read
//   addr  bank address
//   wdata write data
//   ack   1-cycle completion pulse from the arbiter
interface mem_bank_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;

    modport master (output req, output we, output addr, output wdata, input ack);
    modport slave  (input req, input we, input addr, input wdata, output ack);
endinterface

// File: rtl/mem_bank_arbiter.sv
// Two-requester round-robin arbiter and 3-cycle access sequencer for one
// byte-wide memory bank (sync write, combinational read).
//   clk_i, rst_i     clock, synchronous active-high reset
//   req0_if/req1_if  requester buses (slave side), ack driven here
//   rdata_o          registered read data, valid with a read ack
//   busy_o           high in ACCESS and DONE
//   mem_addr_o       bank address (holds last latched request)
//   mem_wdata_o      bank write data (holds last latched request)
//   mem_write_c_o    bank write strobe, ACCESS only, gated by reset
//   mem_read_c_o     bank read strobe, ACCESS only, gated by reset
//   mem_rdata_i      bank read data
module mem_bank_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_bank_arbiter_if.slave req0_if,
    mem_bank_arbiter_if.slave req1_if,
    output logic [DW-1:0]  rdata_o,
    output logic           busy_o,
    output logic [AW-1:0]  mem_addr_o,
    output logic [DW-1:0]  mem_wdata_o,
    output logic           mem_write_c_o,
    output logic           mem_read_c_o,
    input  logic [DW-1:0]  mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          grant_c;

    // Winner: the sole requester, or the one that did not win last time.
    assign grant_c = (req0_if.req && req1_if.req) ? ~last_q : req1_if.req;

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_if.req || req1_if.req) begin
                    win_d   = grant_c;
                    we_d    = grant_c ? req1_if.we    : req0_if.we;
                    addr_d  = grant_c ? req1_if.addr  : req0_if.addr;
                    wdata_d = grant_c ? req1_if.wdata : req0_if.wdata;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = mem_rdata_i;
                end
                // Ack becomes visible in DONE.
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                busy_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are gated by reset so an aborted write never commits.
    assign mem_write_c_o = (state_q == ACCESS) &&  we_q && !rst_i;
    assign mem_read_c_o  = (state_q == ACCESS) && !we_q && !rst_i;

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign req0_if.ack = ack0_q;
    assign req1_if.ack = ack1_q;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
module tb_mem_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       fill;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_rdata;
    logic [7:0] bank [256];
    int         cyc;

    mem_bank_arbiter_if #(.AW(8), .DW(8)) r0 ();
    mem_bank_arbiter_if #(.AW(8), .DW(8)) r1 ();

    mem_bank_arbiter #(.AW(8), .DW(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req0_if       (r0),
        .req1_if       (r1),
        .rdata_o       (rdata),
        .busy_o        (busy),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_write_c_o (mem_write),
        .mem_read_c_o  (mem_read),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fval(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Memory bank: synchronous write, combinational read, 0 when not reading.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) bank[i] <= fval(i);
        end else if (mem_write) begin
            bank[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? bank[mem_addr] : 8'h00;

    // Reference model state.
    typedef struct {
        bit         id;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ref_mem [256];
    bit         last;
    logic [7:0] prev_rd;
    int         total = 0;
    int         bad = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Record one granted transaction in grant order.
    function automatic void predict(input bit id, input bit w, input logic [7:0] a,
                                    input logic [7:0] d, input int at);
        exp_t e;
        e.id = id;
        e.at = at;
        if (w) begin
            e.data = prev_rd;
            ref_mem[a] = d;
        end else begin
            e.data = ref_mem[a];
            prev_rd = ref_mem[a];
        end
        exp_q.push_back(e);
        last = id;
    endfunction

    // Monitor: every ack is matched against the next expected transaction.
    always @(negedge clk) begin
        if (r0.ack === 1'b1 || r1.ack === 1'b1) begin
            exp_t e;
            total++;
            if (r0.ack === 1'b1 && r1.ack === 1'b1) begin
                bad++;
                $display("FAIL ack_both: ack0=1 ack1=1 required one-hot (cycle %0d)", cyc);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL ack_unexpected: ack0=%0b ack1=%0b with no pending transaction (cycle %0d)",
                         r0.ack, r1.ack, cyc);
            end else begin
                e = exp_q.pop_front();
                if (r1.ack !== e.id || cyc != e.at || rdata !== e.data || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL ack_check: id=%0b cyc=%0d rdata=%0h busy=%0b required id=%0b cyc=%0d rdata=%0h busy=1",
                             r1.ack, cyc, rdata, busy, e.id, e.at, e.data);
                end
            end
        end
    end

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h10;
            3: return 8'h11;
            default: return 8'($urandom);
        endcase
    endfunction

    // One round: selected requesters raise together, each drops on its ack.
    task automatic run_round(input bit en0, input bit en1,
                             input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                             input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                             input bit drop_early);
        int         c;
        int         guard;
        bit         first;
        bit         pend0;
        bit         pend1;
        bit         wf;
        logic [7:0] af;
        @(negedge clk);
        c = cyc;
        first = (en0 && en1) ? ~last : en1;
        wf = first ? w1 : w0;
        af = first ? a1 : a0;
        predict(first, wf, af, first ? d1 : d0, c + 2);
        if (en0 && en1) predict(~first, first ? w0 : w1, first ? a0 : a1, first ? d0 : d1, c + 5);
        r0.req = en0; r0.we = w0; r0.addr = a0; r0.wdata = d0;
        r1.req = en1; r1.we = w1; r1.addr = a1; r1.wdata = d1;
        pend0 = en0;
        pend1 = en1;
        guard = 0;
        while ((pend0 || pend1) && guard < 12) begin
            @(negedge clk);
            guard++;
            if (guard == 1) begin
                chk("access_busy", 32'(busy), 32'(1));
                chk("access_write", 32'(mem_write), 32'(wf));
                chk("access_read", 32'(mem_read), 32'(!wf));
                chk("access_addr", 32'(mem_addr), 32'(af));
                if (drop_early) begin
                    r0.req = 1'b0;
                    r1.req = 1'b0;
                end
            end
            if (r0.ack === 1'b1) begin r0.req = 1'b0; pend0 = 1'b0; end
            if (r1.ack === 1'b1) begin r1.req = 1'b0; pend1 = 1'b0; end
        end
        if (pend0 || pend1) begin
            total++;
            bad++;
            $display("FAIL round_timeout: pending0=%0b pending1=%0b required both acked", pend0, pend1);
        end
        r0.req = 1'b0;
        r1.req = 1'b0;
    endtask

    // Both requesters read with req held high across n transactions.
    task automatic run_hold(input int n, input logic [7:0] a0, input logic [7:0] a1);
        int c;
        int got;
        int guard;
        bit id;
        @(negedge clk);
        c = cyc;
        id = ~last;
        for (int k = 0; k < n; k++) begin
            predict(id, 1'b0, id ? a1 : a0, 8'h00, c + 2 + 3 * k);
            id = ~id;
        end
        r0.req = 1'b1; r0.we = 1'b0; r0.addr = a0;
        r1.req = 1'b1; r1.we = 1'b0; r1.addr = a1;
        got = 0;
        guard = 0;
        while (got < n && guard < 3 * n + 6) begin
            @(negedge clk);
            guard++;
            if (r0.ack === 1'b1 || r1.ack === 1'b1) got++;
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL hold_timeout: acks=%0d required %0d", got, n);
        end
        r0.req = 1'b0;
        r1.req = 1'b0;
    endtask

    initial begin
        bit         en0, en1, w0, w1, drop;
        int         kind;
        logic [7:0] a0, a1, d0, d1;

        r0.req = 1'b0; r0.we = 1'b0; r0.addr = 8'h00; r0.wdata = 8'h00;
        r1.req = 1'b0; r1.we = 1'b0; r1.addr = 8'h00; r1.wdata = 8'h00;
        rst = 1'b1;
        fill = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = fval(i);
        last = 1'b1;
        prev_rd = 8'h00;
        repeat (3) @(negedge clk);
        fill = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ack0", 32'(r0.ack), 32'(0));
        chk("rst_ack1", 32'(r1.ack), 32'(0));
        chk("rst_write", 32'(mem_write), 32'(0));
        chk("rst_read", 32'(mem_read), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_wdata", 32'(mem_wdata), 32'(0));

        // Simultaneous requests after reset: 0 first, then alternating.
        run_hold(4, 8'h05, 8'hFE);

        // Write then read back through requester 0.
        run_round(1, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, 0);
        run_round(1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 0);

        // Top address and address 0 are independent locations.
        run_round(0, 1, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 0);
        run_round(1, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 0);
        run_round(1, 0, 1, 8'h00, 8'h12, 0, 8'h00, 8'h00, 0);
        run_round(1, 0, 0, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 0);

        // Request dropped during ACCESS still completes.
        run_round(1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 1);
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'(0));

        // Randomized rounds.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            en0 = (kind != 1);
            en1 = (kind != 0);
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = pick_addr();
            a1 = pick_addr();
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            drop = (kind != 2) && ($urandom_range(0, 3) == 0);
            run_round(en0, en1, w0, a0, d0, w1, a1, d1, drop);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during a write ACCESS aborts it.
        run_round(1, 0, 1, 8'h20, 8'h77, 0, 8'h00, 8'h00, 0);
        @(negedge clk);
        r1.req = 1'b1; r1.we = 1'b1; r1.addr = 8'h20; r1.wdata = 8'h3C;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_write", 32'(mem_write), 32'(0));
        chk("abort_read", 32'(mem_read), 32'(0));
        @(negedge clk);
        r1.req = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_rdata", 32'(rdata), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        last = 1'b1;
        prev_rd = 8'h00;
        run_round(1, 0, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00, 0);
        run_round(1, 1, 0, 8'h20, 8'h00, 1, 8'h21, 8'h99, 0);

        // Idle bus stays quiet.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_quiet", {27'd0, mem_write, mem_read, r0.ack, r1.ack, busy}, 32'd0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a task sequence never returns.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
